// File: rtl/can_pkg.sv
// Shared types and constants for the CAN bit destuffer: FSM states, run-counter ops, bus levels.
package can_pkg;

  localparam int CAN_STUFF_LEN = 5;
  localparam int CAN_IDLE_LEN  = 11;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  typedef enum logic [1:0] {
    INTEGRATE = 2'd0,
    IDLE      = 2'd1,
    FRAME     = 2'd2,
    ERROR     = 2'd3
  } can_state_e;

  // How the equal-bit run counter reacts to an accepted sample.
  typedef enum logic [1:0] {
    RUN_KEEP  = 2'd0,
    RUN_ZERO  = 2'd1,
    RUN_ONE   = 2'd2,
    RUN_COUNT = 2'd3
  } run_op_e;

endpackage

// File: rtl/can_bit_destuffer_if.sv
// Sample stream from bit timing in, destuffed stream and status to the frame receiver out.
interface can_bit_destuffer_if;

  logic sample_valid;
  logic sample_bit;
  logic destuff_en;
  logic out_valid;
  logic out_bit;
  logic sof_detect;
  logic stuff_error;
  logic bus_idle;

  modport master (
    output sample_valid, sample_bit, destuff_en,
    input  out_valid, out_bit, sof_detect, stuff_error, bus_idle
  );

  modport slave (
    input  sample_valid, sample_bit, destuff_en,
    output out_valid, out_bit, sof_detect, stuff_error, bus_idle
  );

endinterface

// File: rtl/can_run_tracker.sv
// Tracks last bus level, equal-bit run length and recessive run length; updates only on upd_i.
// Both counters saturate; rec_clr_i forces the recessive count to zero on the update.
module can_run_tracker
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN,
  parameter int IDLE_LEN  = CAN_IDLE_LEN,
  localparam int RUN_W    = $clog2(STUFF_LEN + 1),
  localparam int REC_W    = $clog2(IDLE_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_i,
  input  logic             bit_i,
  input  run_op_e          run_op_i,
  input  logic             rec_clr_i,
  output logic             last_bit_o,
  output logic             run_sat_o,
  output logic [REC_W-1:0] rec_cnt_o
);

  logic             last_bit_q, last_bit_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [REC_W-1:0] rec_cnt_q, rec_cnt_d;
  logic             rec_sat;

  assign run_sat_o  = (run_cnt_q == RUN_W'(STUFF_LEN));
  assign rec_sat    = (rec_cnt_q == REC_W'(IDLE_LEN));
  assign last_bit_o = last_bit_q;
  assign rec_cnt_o  = rec_cnt_q;

  always_comb begin
    last_bit_d = last_bit_q;
    run_cnt_d  = run_cnt_q;
    rec_cnt_d  = rec_cnt_q;
    if (upd_i) begin
      last_bit_d = bit_i;
      case (run_op_i)
        RUN_ZERO:  run_cnt_d = '0;
        RUN_ONE:   run_cnt_d = RUN_W'(1);
        RUN_COUNT: begin
          if (bit_i != last_bit_q) run_cnt_d = RUN_W'(1);
          else if (!run_sat_o)     run_cnt_d = run_cnt_q + RUN_W'(1);
        end
        default:   run_cnt_d = run_cnt_q;
      endcase
      if (rec_clr_i || bit_i == DOMINANT) rec_cnt_d = '0;
      else if (!rec_sat)                  rec_cnt_d = rec_cnt_q + REC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_bit_q <= RECESSIVE;
      run_cnt_q  <= '0;
      rec_cnt_q  <= '0;
    end else begin
      last_bit_q <= last_bit_d;
      run_cnt_q  <= run_cnt_d;
      rec_cnt_q  <= rec_cnt_d;
    end
  end

endmodule

// File: rtl/can_bit_destuffer.sv
// CAN bus integration, SOF detection and stuff-bit removal; all outputs registered, 1 cycle
// after the sample strobe. No backpressure: the receiver must accept every out_valid.
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN,
  parameter int IDLE_LEN  = CAN_IDLE_LEN
) (
  input  logic clk,
  input  logic rst,
  can_bit_destuffer_if.slave bus
);

  localparam int REC_W = $clog2(IDLE_LEN + 1);

  can_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             out_bit_q, out_bit_d;
  logic             sof_q, sof_d;
  logic             err_q, err_d;
  logic             idle_q, idle_d;

  run_op_e          run_op;
  logic             rec_clr;
  logic             last_bit;
  logic             run_sat;
  logic [REC_W-1:0] rec_cnt;
  logic             rec_hit;

  can_run_tracker #(
    .STUFF_LEN (STUFF_LEN),
    .IDLE_LEN  (IDLE_LEN)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .upd_i      (bus.sample_valid),
    .bit_i      (bus.sample_bit),
    .run_op_i   (run_op),
    .rec_clr_i  (rec_clr),
    .last_bit_o (last_bit),
    .run_sat_o  (run_sat),
    .rec_cnt_o  (rec_cnt)
  );

  // True when this recessive sample is the one that completes the idle run.
  assign rec_hit = (bus.sample_bit == RECESSIVE) && (rec_cnt >= REC_W'(IDLE_LEN - 1));

  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    out_bit_d   = out_bit_q;
    sof_d       = 1'b0;
    err_d       = 1'b0;
    idle_d      = idle_q;
    run_op      = RUN_KEEP;
    rec_clr     = 1'b0;
    if (bus.sample_valid) begin
      case (state_q)
        INTEGRATE, ERROR: begin
          if (rec_hit) begin
            state_d = IDLE;
            idle_d  = 1'b1;
          end
        end
        IDLE: begin
          if (bus.sample_bit == DOMINANT) begin
            out_valid_d = 1'b1;
            out_bit_d   = DOMINANT;
            sof_d       = 1'b1;
            idle_d      = 1'b0;
            state_d     = FRAME;
            run_op      = RUN_ONE;
          end
        end
        FRAME: begin
          if (bus.destuff_en) begin
            if (run_sat) begin
              if (bus.sample_bit == last_bit) begin
                err_d   = 1'b1;
                state_d = ERROR;
                rec_clr = 1'b1;
              end else begin
                run_op = RUN_ONE;
              end
            end else begin
              out_valid_d = 1'b1;
              out_bit_d   = bus.sample_bit;
              run_op      = RUN_COUNT;
            end
          end else begin
            // Outside the stuffed region the bit is still delivered even on the idle-completing sample.
            out_valid_d = 1'b1;
            out_bit_d   = bus.sample_bit;
            run_op      = RUN_ZERO;
            if (rec_hit) begin
              state_d = IDLE;
              idle_d  = 1'b1;
            end
          end
        end
        default: state_d = INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INTEGRATE;
      out_valid_q <= 1'b0;
      out_bit_q   <= RECESSIVE;
      sof_q       <= 1'b0;
      err_q       <= 1'b0;
      idle_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      sof_q       <= sof_d;
      err_q       <= err_d;
      idle_q      <= idle_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_bit     = out_bit_q;
  assign bus.sof_detect  = sof_q;
  assign bus.stuff_error = err_q;
  assign bus.bus_idle    = idle_q;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Scoreboarded bench for can_bit_destuffer: expected bits/errors queued at drive time, checked by a monitor.
module tb_can_bit_destuffer;

  localparam int NONE = 0;
  localparam int OUT  = 1;
  localparam int ERR  = 2;

  typedef struct {
    logic b;
    logic sof;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t out_q[$];
  int   err_q[$];

  can_bit_destuffer_if bus_if ();

  can_bit_destuffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every out_valid / stuff_error must match the head of its queue, one cycle after the sample.
  always @(negedge clk) begin
    if (rst) begin
      if (bus_if.out_valid === 1'b1) begin
        checks++;
        if (out_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_valid cyc=%0d got bit=%b sof=%b required no output", cyc, bus_if.out_bit, bus_if.sof_detect);
        end else begin
          exp_t e;
          e = out_q.pop_front();
          if (bus_if.out_bit !== e.b || bus_if.sof_detect !== e.sof || cyc !== e.cyc) begin
            errors++;
            $display("FAIL out_stream got bit=%b sof=%b cyc=%0d required bit=%b sof=%b cyc=%0d",
                     bus_if.out_bit, bus_if.sof_detect, cyc, e.b, e.sof, e.cyc);
          end
        end
      end else if (bus_if.sof_detect !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL sof_without_valid cyc=%0d got sof=%b required 0", cyc, bus_if.sof_detect);
      end
      if (bus_if.stuff_error === 1'b1) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_stuff_error cyc=%0d got 1 required 0", cyc);
        end else begin
          int ec;
          ec = err_q.pop_front();
          if (cyc !== ec) begin
            errors++;
            $display("FAIL stuff_error_time got cyc=%0d required cyc=%0d", cyc, ec);
          end
        end
      end
    end
  end

  // Called at a negedge; presents one sample for one cycle, then idles for gap cycles.
  task automatic drive(input logic b, input logic en, input int kind, input logic sof, input int gap);
    bus_if.sample_valid = 1'b1;
    bus_if.sample_bit   = b;
    bus_if.destuff_en   = en;
    if (kind == OUT) out_q.push_back('{b, sof, cyc + 1});
    else if (kind == ERR) err_q.push_back(cyc + 1);
    @(negedge clk);
    bus_if.sample_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_idle(input logic exp, input string name);
    checks++;
    if (bus_if.bus_idle !== exp) begin
      errors++;
      $display("FAIL %s bus_idle got %b required %b", name, bus_if.bus_idle, exp);
    end
  endtask

  // destuff_en low: eleven recessive bits, all delivered; idle only on the eleventh.
  task automatic leave_frame(input int gap);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, OUT, 1'b0, gap);
    check_idle(1'b0, "eof_10_recessive");
    drive(1'b1, 1'b0, OUT, 1'b0, gap);
    check_idle(1'b1, "eof_11_recessive");
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus_if.sample_valid = 1'b0;
    bus_if.sample_bit   = 1'b1;
    bus_if.destuff_en   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.out_bit !== 1'b1 || bus_if.sof_detect !== 1'b0 ||
        bus_if.stuff_error !== 1'b0 || bus_if.bus_idle !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got v=%b b=%b sof=%b err=%b idle=%b required 0 1 0 0 0",
               bus_if.out_valid, bus_if.out_bit, bus_if.sof_detect, bus_if.stuff_error, bus_if.bus_idle);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_integration;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, NONE, 1'b0, 0);
    drive(1'b0, 1'b0, NONE, 1'b0, 0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, NONE, 1'b0, 0);
    check_idle(1'b0, "integrate_10_after_dominant");
    drive(1'b1, 1'b0, NONE, 1'b0, 0);
    check_idle(1'b1, "integrate_11");
    drive(1'b1, 1'b0, NONE, 1'b0, 0);
    check_idle(1'b1, "idle_ignores_recessive");
  endtask

  // Stream 0,0,0,0,0,[stuff 1],1,0 -> delivered 0,0,0,0,0,1,0.
  task automatic test_destuff(input int gap);
    check_idle(1'b1, "destuff_start_idle");
    drive(1'b0, 1'b1, OUT, 1'b1, gap);
    check_idle(1'b0, "sof_clears_idle");
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, OUT, 1'b0, gap);
    drive(1'b1, 1'b1, NONE, 1'b0, gap);
    drive(1'b1, 1'b1, OUT, 1'b0, gap);
    drive(1'b0, 1'b1, OUT, 1'b0, gap);
    leave_frame(gap);
  endtask

  task automatic test_stuff_recessive;
    drive(1'b0, 1'b1, OUT, 1'b1, 0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, OUT, 1'b0, 0);
    drive(1'b0, 1'b1, NONE, 1'b0, 0);
    drive(1'b0, 1'b1, OUT, 1'b0, 0);
    leave_frame(0);
  endtask

  task automatic test_stuff_error;
    drive(1'b0, 1'b1, OUT, 1'b1, 0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, OUT, 1'b0, 0);
    drive(1'b0, 1'b1, ERR, 1'b0, 0);
    drive(1'b0, 1'b1, NONE, 1'b0, 0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, NONE, 1'b0, 0);
    check_idle(1'b0, "error_10_recessive");
    drive(1'b1, 1'b1, NONE, 1'b0, 0);
    check_idle(1'b1, "error_11_recessive");
  endtask

  task automatic test_no_destuff;
    drive(1'b0, 1'b1, OUT, 1'b1, 0);
    drive(1'b1, 1'b1, OUT, 1'b0, 0);
    drive(1'b0, 1'b1, OUT, 1'b0, 0);
    leave_frame(0);
  endtask

  task automatic test_reset_midframe;
    drive(1'b0, 1'b1, OUT, 1'b1, 0);
    drive(1'b0, 1'b1, OUT, 1'b0, 0);
    bus_if.sample_valid = 1'b1;
    bus_if.sample_bit   = 1'b0;
    bus_if.destuff_en   = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_bit !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_output got v=%b b=%b required 1 0", bus_if.out_valid, bus_if.out_bit);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.out_bit !== 1'b1 || bus_if.sof_detect !== 1'b0 ||
        bus_if.stuff_error !== 1'b0 || bus_if.bus_idle !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b b=%b sof=%b err=%b idle=%b required 0 1 0 0 0",
               bus_if.out_valid, bus_if.out_bit, bus_if.sof_detect, bus_if.stuff_error, bus_if.bus_idle);
    end
    @(negedge clk);
    bus_if.sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, NONE, 1'b0, 0);
    check_idle(1'b0, "after_reset_dominant");
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, NONE, 1'b0, 0);
    check_idle(1'b0, "after_reset_10_recessive");
    drive(1'b1, 1'b0, NONE, 1'b0, 0);
    check_idle(1'b1, "after_reset_11_recessive");
    drive(1'b0, 1'b1, OUT, 1'b1, 0);
    leave_frame(0);
  endtask

  task automatic test_back_to_back;
    test_destuff(0);
    test_destuff(15);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_integration();
    test_destuff(2);
    test_stuff_recessive();
    test_stuff_error();
    test_no_destuff();
    test_reset_midframe();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (out_q.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs got %0d pending required 0", out_q.size());
    end
    checks++;
    if (err_q.size() != 0) begin
      errors++;
      $display("FAIL missing_stuff_error got %0d pending required 0", err_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
